// File: rtl/hex_update_arbiter_pkg.sv
// Shared constants for the hex update arbiter: segment table, blank pattern,
// FSM encoding and the round-robin search helper.
package hex_update_arbiter_pkg;

  localparam int unsigned N_REQ = 4;

  // Active-low, bit order gfedcba; all segments off.
  localparam logic [6:0] BLANK_PATTERN = 7'b1111111;

  // Active-low seven-segment patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // First requester with req set, searching upward from ptr modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] g;
    logic [1:0] c;
    logic       found;
    g     = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      c = ptr + i[1:0];
      if (!found && req[c]) begin
        g     = c;
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/hex_update_arbiter_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern (gfedcba), pure table lookup.
module hex_to_seg
  import hex_update_arbiter_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/hex_update_arbiter.sv
// Round-robin arbiter sharing a single hex-to-seven-segment decoder among
// four requesters, each owning one display digit HEX0..HEX3.
module hex_update_arbiter
  import hex_update_arbiter_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] val,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] idx;
  logic [3:0] nib;
  logic [6:0] pat;
  logic [6:0] seg;
  logic [1:0] grant;

  assign grant = rr_pick(req, ptr);

  hex_to_seg u_dec (
    .hex (nib),
    .seg (seg)
  );

  // Arbitration FSM: grant in IDLE, register decoder output, commit to digit.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      nib   <= '0;
      pat   <= BLANK_PATTERN;
      HEX0  <= BLANK_PATTERN;
      HEX1  <= BLANK_PATTERN;
      HEX2  <= BLANK_PATTERN;
      HEX3  <= BLANK_PATTERN;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            idx   <= grant;
            nib   <= val[{grant, 2'b00} +: 4];
            state <= DECODE;
          end
        end
        DECODE: begin
          pat   <= seg;
          state <= COMMIT;
        end
        COMMIT: begin
          case (idx)
            2'd0:    HEX0 <= pat;
            2'd1:    HEX1 <= pat;
            2'd2:    HEX2 <= pat;
            default: HEX3 <= pat;
          endcase
          ptr   <= idx + 2'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acknowledge the committed digit for the single COMMIT cycle.
  always_comb begin
    ack = '0;
    if (state == COMMIT) ack[idx] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_update_arbiter.sv
// Directed self-checking bench for hex_update_arbiter.
module tb_hex_update_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] val;
  logic [3:0]  ack;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int checks;
  int errors;

  // Hand-written reference patterns, active-low gfedcba.
  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] BLANK = 7'b1111111;

  hex_update_arbiter dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .req      (req),
    .val      (val),
    .ack      (ack),
    .busy     (busy),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  // One isolated transaction: present at grant cycle, expect ack two cycles later.
  task automatic run_one(input string tag, input logic [3:0] r, input logic [15:0] v,
                         input logic [3:0] exp_ack);
    req = r;
    val = v;
    tick();
    tick();
    chk(tag, {12'h0, ack}, {12'h0, exp_ack});
    req = '0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    req    = '0;
    val    = '0;
    #1 resetn = 1'b0;
    repeat (3) tick();
    chk("rst_hex0", {9'h0, hex0}, {9'h0, BLANK});
    chk("rst_ack",  {12'h0, ack}, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    resetn = 1'b1;
    tick();
    chk("post_rst_hex", {hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]}, 16'hFFFF);
    chk("post_rst_busy", {15'h0, busy}, 16'h0);

    // Single request on digit 0.
    req = 4'b0001;
    val = 16'h0001;
    chk("single_T_busy", {15'h0, busy}, 16'h0);
    tick();
    chk("single_T1_busy", {15'h0, busy}, 16'h1);
    chk("single_T1_ack", {12'h0, ack}, 16'h0);
    tick();
    chk("single_T2_ack", {12'h0, ack}, 16'h1);
    chk("single_T2_hex0_old", {9'h0, hex0}, {9'h0, BLANK});
    req = '0;
    tick();
    chk("single_hex0", {9'h0, hex0}, {9'h0, 7'b1111001});
    chk("single_hex1", {9'h0, hex1}, {9'h0, BLANK});
    chk("single_hex3", {9'h0, hex3}, {9'h0, BLANK});
    chk("single_ack_done", {12'h0, ack}, 16'h0);
    chk("single_busy_done", {15'h0, busy}, 16'h0);

    // Round-robin with all four requesting; pointer back at 0 after reset.
    do_reset();
    req = 4'b1111;
    val = 16'h3210;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_busy", {15'h0, busy}, 16'h1);
      tick();
      chk($sformatf("rr_ack%0d", k), {12'h0, ack}, 16'(1 << (k % 4)));
      if (k == 7) req = '0;
      tick();
    end
    chk("rr_hex0", {9'h0, hex0}, {9'h0, 7'b1000000});
    chk("rr_hex1", {9'h0, hex1}, {9'h0, 7'b1111001});
    chk("rr_hex2", {9'h0, hex2}, {9'h0, 7'b0100100});
    chk("rr_hex3", {9'h0, hex3}, {9'h0, 7'b0110000});

    // Pointer wrapped to 0 after grant to 3: requester 0 wins over 3.
    req = 4'b1001;
    val = 16'h5008;
    tick();
    tick();
    chk("wrap_first", {12'h0, ack}, 16'h1);
    req = 4'b1000;
    tick();
    tick();
    tick();
    chk("wrap_second", {12'h0, ack}, 16'h8);
    req = '0;
    tick();
    chk("wrap_hex0", {9'h0, hex0}, {9'h0, 7'b0000000});
    chk("wrap_hex3", {9'h0, hex3}, {9'h0, 7'b0010010});

    // Sweep all values through digit 2.
    for (int v = 0; v < 16; v++) begin
      run_one("sweep_ack", 4'b0100, 16'(v << 8), 4'b0100);
      chk($sformatf("sweep_hex2_%0h", v), {9'h0, hex2}, {9'h0, seg_ref[v]});
    end
    chk("sweep_hex0_hold", {9'h0, hex0}, {9'h0, 7'b0000000});

    // Early drop: req/val removed the cycle after grant.
    req = 4'b0010;
    val = 16'h00A0;
    tick();
    req = '0;
    val = '0;
    tick();
    chk("early_ack", {12'h0, ack}, 16'h2);
    tick();
    chk("early_hex1", {9'h0, hex1}, {9'h0, 7'b0001000});

    // Async reset while in DECODE: pointer is 2 beforehand.
    req = 4'b0010;
    val = 16'h0030;
    tick();
    chk("mid_busy", {15'h0, busy}, 16'h1);
    req = '0;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {15'h0, busy}, 16'h0);
    chk("mid_rst_hex", {hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]}, 16'hFFFF);
    chk("mid_rst_hex1", {9'h0, hex1}, {9'h0, BLANK});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_rst_noack", {12'h0, ack}, 16'h0);
    end
    resetn = 1'b1;
    tick();
    chk("mid_rel_hex1", {9'h0, hex1}, {9'h0, BLANK});
    req = 4'b1010;
    val = 16'h9070;
    tick();
    tick();
    chk("mid_ptr0_ack", {12'h0, ack}, 16'h2);
    req = '0;
    tick();
    chk("mid_hex1", {9'h0, hex1}, {9'h0, 7'b1111000});
    chk("mid_hex3", {9'h0, hex3}, {9'h0, BLANK});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_update_arbiter.md
Name: hex_update_arbiter

Overview:
- Round-robin arbiter that shares one hex-to-seven-segment decoder among four requesters.
- Each requester owns one display digit (HEX0..HEX3) and asks to update it by presenting a 4-bit value with a request.
- The arbiter grants one requester at a time, decodes its value and latches the pattern into that digit's output register, then acknowledges.
- Sits between the lab datapaths (switch logic, counters) and the board's seven-segment outputs.

Parameters:
- N_REQ, 4, number of requesters/digits; fixed at 4 for this revision, so the port list is written for 4.
- BLANK_PATTERN, 7'b1111111, active-low pattern driven on a digit after reset (all segments off).

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  4  req[k]=1 requests an update of digit k.
- val  input  16  val[4k+3:4k] is the hex value for requester k; sampled at grant.
- ack  output  4  one-cycle pulse on ack[k] when HEXk has been written.
- busy  output  1  high while a transaction is in progress (state not IDLE).
- HEX0  output  7  digit 0 pattern, active-low, bit order gfedcba (bit6=g, bit0=a).
- HEX1  output  7  digit 1 pattern, same encoding as HEX0.
- HEX2  output  7  digit 2 pattern, same encoding as HEX0.
- HEX3  output  7  digit 3 pattern, same encoding as HEX0.

Behaviour:
- Reset (resetn=0, asynchronous, takes effect immediately, even mid-transaction):
  - HEX0..HEX3 = BLANK_PATTERN, ack = 0, busy = 0.
  - State = IDLE, round-robin pointer = 0, latched index/value = 0.
  - An in-flight transaction is discarded: no ack is issued and no digit is written.
- FSM states IDLE -> DECODE -> COMMIT -> IDLE:
  - IDLE: if any req bit is high, grant the first requester found searching upward from the pointer, modulo 4. Latch the index (2 bits) and val nibble, then go to DECODE. If no req is high, stay in IDLE. req is sampled only in IDLE.
  - DECODE: register the decoder output for the latched value, then go to COMMIT.
  - COMMIT: write the registered pattern into HEX[index] and assert ack[index] for exactly this cycle. Set pointer = index+1 (mod 4; index 3 wraps to 0), then go to IDLE.
- Timing:
  - Grant cycle is T, HEXk updates at the edge ending T+2, and ack[k] is high during T+2.
  - Throughput is one update per 3 cycles. busy is high in DECODE and COMMIT.
  - Digits not being written hold their value.
- Requester protocol:
  - Hold req[k] and val until ack[k].
  - Deasserting req after grant does not abort; the latched value is still written and acked.
  - A req still high in the IDLE cycle after ack is treated as a new request. Requesters drop req on ack.
- Fairness: with all four requesting continuously, grant order is 0,1,2,3,0,... and each digit is updated once per 12 cycles. No requester waits more than 3 transactions.
- Decoder: covers all 16 values; no invalid input exists. Active-low patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No X propagation: all outputs are registered, and ack is decoded from registered state/index.

Decomposition:
- Shared package holds:
  - the 16-entry SEG_TABLE constant;
  - BLANK_PATTERN;
  - the state encoding (IDLE=2'd0, DECODE=2'd1, COMMIT=2'd2; 2'd3 recovers to IDLE).
- Sub-module hex_to_seg (4-bit in, 7-bit active-low out, purely combinational table lookup). It is instantiated once and is the shared resource under arbitration.
- The arbiter, FSM and output registers stay in hex_update_arbiter.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, then release -> HEX0..3=1111111, ack=0000, busy=0, pointer=0.
- Single request: req=0001, val[3:0]=4'h1 -> grant at T, busy=1 at T+1, HEX0=1111001 and ack=0001 at T+2, other digits unchanged.
- Round-robin fairness: req=1111 held, vals 0,1,2,3 -> acks in order 0001,0010,0100,1000, each 3 cycles apart, then repeating from 0001. Final HEX0..3 = 1000000,1111001,0100100,0110000.
- Pointer wrap: after a grant to 3, assert req=1001 -> requester 0 granted before 3. Exhaustively sweep val 0..F on digit 2 and check HEX2 against the table.
- Early drop: req[1] falls the cycle after grant with val=4'hA -> HEX1=0001000 and ack=0010 still occur at T+2.
- Async reset mid-transaction: resetn=0 during DECODE -> outputs clear immediately with no ack pulse, and after release the next request starts from requester 0.
